matmul_result_streamer: RTL and testbench
=========================================

# matmul_result_streamer

Output stage placed directly downstream of the matrix-multiply controller and its two MAC units. It captures the nine 16-bit result elements of the 3x3 product as the controller's final mux delivers them, in arbitrary index order. Once all nine are present, it streams them out in row-major index order (0..8) over a valid/ready interface, which provides the "dout" phase that follows the controller's last state. It also flags protocol errors such as duplicate, out-of-range or overrun writes.

## Interface
- `DATA_W`, default 16: result element width.
- `N_RESULTS`, default 9: elements per frame (3x3 product).
- `IDX_W`, default 4: index width; must satisfy 2^IDX_W >= N_RESULTS.

- `clk`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: asynchronous, active-low; the polarity and synchronicity are fixed.
- `clr`, in, 1: synchronous clear; same effect as reset, but takes effect on the clock edge.
- `res_valid`, in, 1: a result element is present this cycle.
- `res_idx`, in, IDX_W: element index (row*3+col).
- `res_data`, in, DATA_W: element value, two's complement.
- `dout`, out, DATA_W: streamed element.
- `dout_valid`, out, 1: `dout` holds a valid element.
- `dout_ready`, in, 1: downstream accepts.
- `dout_last`, out, 1: the current `dout` is element N_RESULTS-1.
- `busy`, out, 1: state is not IDLE.
- `err`, out, 3: sticky error flags {overrun, dup, range}; cleared only by reset or `clr`.

## Operation
- The FSM has three states: IDLE, COLLECT and STREAM. Encoding IDLE=2'b00, COLLECT=2'b01, STREAM=2'b10.
- The block keeps an N_RESULTS-entry buffer plus a `present` bitmap of N_RESULTS bits.

- **IDLE:**
  - The bitmap is empty.
  - `res_valid` with a legal index writes the entry, sets its bit and moves to COLLECT.
  - If N_RESULTS==1, that write goes straight to STREAM.

- **COLLECT:**
  - `res_valid` with a legal, not-yet-present index writes the entry and sets its bit.
  - When the write completes the bitmap, the next state is STREAM and the read pointer is set to 0.

- **STREAM:**
  - The element at the read pointer drives `dout`.
  - On a transfer (`dout_valid` and `dout_ready` both high), the pointer increments.
  - A transfer of element N_RESULTS-1 clears the bitmap and returns the FSM to IDLE.

- **Error and boundary rules:**
  - `res_idx` >= N_RESULTS: the write is ignored and `err[0]` is set. This holds in every state.
  - Index already present in COLLECT: the write is ignored (the first value is kept) and `err[1]` is set.
  - `res_valid` during STREAM: the write is dropped and `err[2]` is set. The controller has no backpressure, so the block does not stall.
  - `clr` and `res_valid` in the same cycle: `clr` wins and the write is lost.
  - Reset or `clr` mid-frame or mid-stream: the FSM returns to IDLE, the bitmap, pointer and `err` are cleared, and `dout_valid` drops.
  - Buffer contents are not cleared by reset. They are don't-care until written.
- Data passes through unmodified. No arithmetic is performed on `res_data`.

## Timing
- **Reset values:** `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `err`=3'b000, FSM=IDLE.
- All outputs are registered.
- **Input sampling:** `res_valid`, `res_idx` and `res_data` are sampled on the rising edge. The upstream controller, which updates on the falling edge, meets this with half-cycle setup.
- **Stream-start latency:** if the edge E captures the final missing element, `dout_valid`=1 with `dout`=element 0 in the cycle after E.
- **Hold rule:** while `dout_valid`=1 and `dout_ready`=0, `dout` and `dout_last` stay stable.
- **Back-to-back throughput:** with `dout_ready` held high, one element transfers per cycle, so nine cycles cover the whole frame.
- **`dout_last`:** high exactly when `dout_valid`=1 and the pointer is N_RESULTS-1.
- **End of stream:** in the cycle after the last transfer, `dout_valid`=0 and `busy`=0. A new frame's first write is accepted in that cycle.
- **`busy`:** goes to 1 in the cycle after the first accepted write.

## Structure
- The package `matmul_pkg` holds:
  - DATA_W, N_RESULTS and IDX_W;
  - the state encoding constants;
  - the error-bit positions ERR_RANGE=0, ERR_DUP=1 and ERR_OVR=2.
- The sub-module `result_regfile` is an N_RESULTS x DATA_W storage with one synchronous write port and one combinational read port. The FSM, bitmap, pointer and error logic stay in the top level.

## Test plan
- **Out-of-order fill:** write indices 8,4,3,0,7,1,6,2,5 with data 0x0100+idx, `dout_ready`=1. Expect:
  - `dout` = 0x0100..0x0108 on nine consecutive cycles;
  - `dout_last` only with 0x0108;
  - `busy`=0 afterwards.
- **Backpressure:** fill the frame, then toggle `dout_ready` 1,0,0,1,… Expect `dout` stable during every stalled cycle, no element lost or repeated, and a total of 9 transfers.
- **Duplicate write:** write idx 2 = 0x1111, then idx 2 = 0x2222, then the rest. Expect element 2 to stream as 0x1111 and `err`=3'b010.
- **Range and overrun:**
  - Write idx 12 in IDLE: expect `err[0]`=1 and the FSM to stay in IDLE.
  - Write during STREAM: expect `err[2]`=1 and the streamed data unchanged.
- **Reset mid-stream:** assert `reset`=0 after 4 transfers. Expect `dout_valid`=0, `busy`=0 and `err`=0 asynchronously. A fresh fill of 0x00AA..0x00B2 then streams from element 0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared widths, FSM encoding and error-bit positions for the matmul result streamer.
package matmul_pkg;

  localparam int DATA_W    = 16;
  localparam int N_RESULTS = 9;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_STREAM  = 2'b10
  } state_e;

  localparam int ERR_RANGE = 0;
  localparam int ERR_DUP   = 1;
  localparam int ERR_OVR   = 2;

endpackage

// File: rtl/result_regfile.sv
// Result element storage: one synchronous write port, one combinational read port.
module result_regfile #(
  parameter int DATA_W    = matmul_pkg::DATA_W,
  parameter int N_RESULTS = matmul_pkg::N_RESULTS,
  parameter int IDX_W     = matmul_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [N_RESULTS];

  // Element write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/matmul_result_streamer.sv
// Captures the nine 3x3 product elements in any order, then streams them out
// in row-major order over valid/ready with sticky protocol-error flags.
module matmul_result_streamer #(
  parameter int DATA_W    = matmul_pkg::DATA_W,
  parameter int N_RESULTS = matmul_pkg::N_RESULTS,
  parameter int IDX_W     = matmul_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              res_valid,
  input  logic [IDX_W-1:0]  res_idx,
  input  logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic [2:0]        err
);

  import matmul_pkg::*;

  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N_RESULTS - 1);
  localparam logic [IDX_W:0]       IDX_LIMIT   = (IDX_W + 1)'(N_RESULTS);
  localparam logic [N_RESULTS-1:0] ALL_PRESENT = {N_RESULTS{1'b1}};

  state_e                state_r, state_s;
  logic [N_RESULTS-1:0]  present_r, present_s, idx_bit_s;
  logic [IDX_W-1:0]      ptr_r, ptr_s;
  logic [2:0]            err_r, err_s;
  logic [DATA_W-1:0]     dout_r, dout_s, rd_data_s;
  logic                  dout_valid_r, dout_valid_s;
  logic                  dout_last_r, dout_last_s;
  logic                  busy_r, busy_s;
  logic                  legal_s, hit_s, wr_en_s, full_s, xfer_s;

  assign legal_s   = ({1'b0, res_idx} < IDX_LIMIT);
  assign idx_bit_s = N_RESULTS'(1'b1) << res_idx;
  assign hit_s     = |(present_r & idx_bit_s);
  assign wr_en_s   = res_valid & legal_s & ~hit_s & ~clr & (state_r != ST_STREAM);
  assign full_s    = ((present_r | idx_bit_s) == ALL_PRESENT);
  assign xfer_s    = dout_valid_r & dout_ready;

  result_regfile #(
    .DATA_W    (DATA_W),
    .N_RESULTS (N_RESULTS),
    .IDX_W     (IDX_W)
  ) u_regfile (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_idx  (res_idx),
    .wr_data (res_data),
    .rd_idx  (ptr_s),
    .rd_data (rd_data_s)
  );

  // FSM state register; clr behaves as a clocked copy of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else if (clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        if (wr_en_s) begin
          state_s = full_s ? ST_STREAM : ST_COLLECT;
        end else begin
          state_s = state_r;
        end
      end
      ST_STREAM: begin
        if (xfer_s && (ptr_r == LAST_IDX)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_STREAM;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values for bitmap, read pointer, error flags and the registered outputs.
  always_comb begin
    present_s = present_r;
    ptr_s     = ptr_r;
    if ((state_r == ST_STREAM) && (state_s == ST_IDLE)) begin
      present_s = {N_RESULTS{1'b0}};
      ptr_s     = {IDX_W{1'b0}};
    end else if (wr_en_s) begin
      present_s = present_r | idx_bit_s;
      ptr_s     = {IDX_W{1'b0}};
    end else if (xfer_s) begin
      ptr_s     = ptr_r + IDX_W'(1);
    end else begin
      present_s = present_r;
      ptr_s     = ptr_r;
    end

    err_s            = err_r;
    err_s[ERR_RANGE] = err_r[ERR_RANGE] | (res_valid & ~legal_s);
    err_s[ERR_DUP]   = err_r[ERR_DUP] | (res_valid & legal_s & hit_s & (state_r == ST_COLLECT));
    err_s[ERR_OVR]   = err_r[ERR_OVR] | (res_valid & (state_r == ST_STREAM));

    dout_valid_s = (state_s == ST_STREAM);
    dout_last_s  = dout_valid_s & (ptr_s == LAST_IDX);
    busy_s       = (state_s != ST_IDLE);
    // The element completing the frame may be element 0 itself, so bypass the regfile.
    if (!dout_valid_s) begin
      dout_s = {DATA_W{1'b0}};
    end else if (wr_en_s && (res_idx == ptr_s)) begin
      dout_s = res_data;
    end else begin
      dout_s = rd_data_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      present_r    <= {N_RESULTS{1'b0}};
      ptr_r        <= {IDX_W{1'b0}};
      err_r        <= 3'b000;
      dout_r       <= {DATA_W{1'b0}};
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else if (clr) begin
      present_r    <= {N_RESULTS{1'b0}};
      ptr_r        <= {IDX_W{1'b0}};
      err_r        <= 3'b000;
      dout_r       <= {DATA_W{1'b0}};
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      present_r    <= present_s;
      ptr_r        <= ptr_s;
      err_r        <= err_s;
      dout_r       <= dout_s;
      dout_valid_r <= dout_valid_s;
      dout_last_r  <= dout_last_s;
      busy_r       <= busy_s;
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign dout_last  = dout_last_r;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Randomized directed bench for matmul_result_streamer against a frame-level reference model.
module tb_matmul_result_streamer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic        res_valid = 1'b0;
  logic [3:0]  res_idx = 4'd0;
  logic [15:0] res_data = 16'd0;
  logic        dout_ready = 1'b0;
  logic [15:0] dout;
  logic        dout_valid, dout_last, busy;
  logic [2:0]  err;

  int vecs = 0;
  int fails = 0;

  // Reference model: frame contents, which indices have arrived, sticky errors.
  logic [15:0] m_val [9];
  logic [8:0]  m_have;
  logic [2:0]  m_err;
  bit          m_streaming;
  logic [3:0]  order [9];

  always #5 clk = ~clk;

  matmul_result_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .res_data   (res_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mclear();
    m_have      = 9'd0;
    m_err       = 3'b000;
    m_streaming = 1'b0;
  endtask

  task automatic shuffle();
    int j;
    logic [3:0] t;
    for (int i = 0; i < 9; i++) order[i] = 4'(i);
    for (int i = 8; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
  endtask

  // Drive one write for one clock and apply the same rules to the model.
  task automatic put(input logic [3:0] idx, input logic [15:0] d);
    res_valid = 1'b1;
    res_idx   = idx;
    res_data  = d;
    if (idx >= 4'd9) m_err[0] = 1'b1;
    if (m_streaming) begin
      m_err[2] = 1'b1;
    end else if (idx < 4'd9) begin
      if (m_have[idx]) begin
        m_err[1] = 1'b1;
      end else begin
        m_have[idx] = 1'b1;
        m_val[idx]  = d;
      end
      if (&m_have) m_streaming = 1'b1;
    end
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic fill(input bit use_base, input logic [15:0] base, input int first);
    for (int i = first; i < 9; i++)
      put(order[i], use_base ? base + 16'(order[i]) : 16'($urandom));
    chk("start_valid", dout_valid, 1);
    chk("start_data", dout, m_val[0]);
    chk("start_last", dout_last, 0);
  endtask

  // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
  task automatic run_stream(input int mode, input int stop_after, input int inj_at);
    int k = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [15:0] held_d = 16'd0;
    logic held_l = 1'b0;
    logic rdy;
    while (k < stop_after && cyc < 80) begin
      if (held) begin
        chk("hold_data", dout, held_d);
        chk("hold_last", dout_last, held_l);
      end
      chk("stream_valid", dout_valid, 1);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      dout_ready = rdy;
      if (cyc == inj_at) begin
        res_valid = 1'b1;
        res_idx   = 4'($urandom_range(0, 8));
        res_data  = 16'hDEAD;
        m_err[2]  = 1'b1;
      end
      if (rdy) begin
        chk("stream_data", dout, m_val[4'(k)]);
        chk("stream_last", dout_last, (k == 8));
        k++;
        held = 1'b0;
      end else begin
        held   = 1'b1;
        held_d = dout;
        held_l = dout_last;
      end
      @(negedge clk);
      res_valid = 1'b0;
      cyc++;
    end
    dout_ready = 1'b0;
    chk("xfer_count", k, stop_after);
    if (mode == 0) chk("throughput_cycles", cyc, stop_after);
    if (stop_after == 9) begin
      m_streaming = 1'b0;
      m_have      = 9'd0;
      chk("end_valid", dout_valid, 0);
      chk("end_busy", busy, 0);
      chk("end_last", dout_last, 0);
    end
  endtask

  initial begin
    mclear();
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Out-of-order fill with index-tagged data.
    order = '{4'd8, 4'd4, 4'd3, 4'd0, 4'd7, 4'd1, 4'd6, 4'd2, 4'd5};
    chk("idle_busy", busy, 0);
    put(4'd8, 16'h0108);
    chk("busy_first", busy, 1);
    chk("collect_valid", dout_valid, 0);
    fill(1'b1, 16'h0100, 1);
    run_stream(0, 9, -1);
    chk("ooo_err", err, 0);

    // Backpressure.
    shuffle();
    fill(1'b0, 16'h0000, 0);
    run_stream(1, 9, -1);

    // Duplicate write keeps the first value.
    shuffle();
    for (int i = 1; i < 9; i++) if (order[i] == 4'd2) begin
      order[i] = order[0];
      order[0] = 4'd2;
    end
    put(4'd2, 16'h1111);
    put(4'd2, 16'h2222);
    fill(1'b0, 16'h0000, 0);
    chk("dup_err", err, m_err);
    chk("dup_err_const", err, 3'b010);
    run_stream(2, 9, -1);

    // Synchronous clear.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mclear();
    chk("clr_err", err, 0);

    // Out-of-range write in IDLE, then overrun during STREAM.
    put(4'd12, 16'hBEEF);
    chk("range_busy", busy, 0);
    chk("range_err", err, m_err);
    shuffle();
    fill(1'b0, 16'h0000, 0);
    run_stream(0, 9, 3);
    chk("ovr_err", err, m_err);
    chk("ovr_err_const", err, 3'b101);

    // clr mid-collect wins over a simultaneous write.
    shuffle();
    put(order[0], 16'h0A0A);
    put(order[1], 16'h0B0B);
    clr       = 1'b1;
    res_valid = 1'b1;
    res_idx   = order[2];
    res_data  = 16'h0C0C;
    @(negedge clk);
    clr       = 1'b0;
    res_valid = 1'b0;
    mclear();
    chk("clr_busy", busy, 0);
    chk("clr_err2", err, 0);
    chk("clr_valid", dout_valid, 0);
    shuffle();
    fill(1'b0, 16'h0000, 0);
    run_stream(2, 9, -1);

    // Asynchronous reset after four transfers.
    put(4'd13, 16'h0000);
    shuffle();
    fill(1'b0, 16'h0000, 0);
    run_stream(0, 4, -1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", dout_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_last", dout_last, 0);
    mclear();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    shuffle();
    fill(1'b1, 16'h00AA, 0);
    run_stream(0, 9, -1);

    // Back-to-back random frames; each first write lands right after the last transfer.
    repeat (4) begin
      shuffle();
      fill(1'b0, 16'h0000, 0);
      run_stream(2, 9, -1);
    end
    chk("final_err", err, m_err);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
